pht_predictor: RTL and testbench
================================

PHT_PREDICTOR -- requirements
Module: pht_predictor

Interface
REQ-001 SHALL have parameter PHT_ENTRIES, default 256, number of counters; power of two, 4..4096.
REQ-002 SHALL have parameter CTR_WIDTH, default 2, bits per counter; 2..4.
REQ-003 SHALL have parameter HYSTERESIS, default 1; 1 = hysteresis update, 0 = saturating update.
REQ-004 SHALL have parameter GHR_WIDTH, default 8, global history bits; used only under GSHARE_EN; 1..log2(PHT_ENTRIES).
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc_F  in  32  fetch-stage PC
- predict_taken_F  out  1  prediction for pc_F
- pred_ctr_F  out  CTR_WIDTH  raw counter read for pc_F
- upd_valid_E  in  1  resolved control-flow instruction in execute
- upd_pc_E  in  32  PC of the resolved instruction
- upd_opcode_E  in  opcode_t  opcode of the resolved instruction
- upd_taken_E  in  1  actual outcome, i.e. br_cond_E for branches
- mispredict_E  in  1  execute-stage mispredict flag
- stat_branches  out  32  count of OP_BRANCH updates
- stat_mispred  out  32  count of updates with mispredict_E=1

Function
REQ-006 SHALL hold PHT_ENTRIES counters of CTR_WIDTH bits in flops; MAX = 2^CTR_WIDTH-1, WNT = 2^(CTR_WIDTH-1)-1.
REQ-007 SHALL index with idx(pc) = pc[log2(PHT_ENTRIES)+1:2]; pc[1:0] ignored.
REQ-008 SHALL read combinationally: pred_ctr_F = PHT[idx(pc_F)]; predict_taken_F = MSB of that counter; zero-cycle latency.
REQ-009 SHALL write only at a rising clk edge with upd_valid_E=1; new value visible to the read path the following cycle.
REQ-010 SHALL, on a same-index read and write in one cycle, return the pre-write value (no bypass).
REQ-011 SHALL, for OP_BRANCH with HYSTERESIS=1: taken gives c==0 -> 1, else MAX; not-taken gives c==MAX -> MAX-1, else 0.
REQ-012 SHALL, for OP_BRANCH with HYSTERESIS=0: taken gives min(c+1,MAX); not-taken gives max(c-1,0); no wrap past either bound.
REQ-013 SHALL, for OP_JAL or OP_JALR, write MAX regardless of upd_taken_E.
REQ-014 SHALL leave the table, GHR and stat_branches unchanged for any other opcode with upd_valid_E=1.
REQ-015 SHALL add 1 to stat_branches per valid OP_BRANCH update, and 1 to stat_mispred per valid update with mispredict_E=1; both wrap modulo 2^32.
REQ-016 SHALL ignore mispredict_E and upd_taken_E when upd_valid_E=0.

Reset
REQ-017 SHALL, while rst=1, asynchronously force every counter to WNT, GHR to 0, and both stat counters to 0.
REQ-018 SHALL give these output reset values: predict_taken_F=0; pred_ctr_F=WNT.
REQ-019 SHALL, on rst asserted mid-update, discard that update; the first write is on the first clk edge with rst=0.

Configuration
REQ-020 SHALL, with GSHARE_EN defined:
- keep a GHR_WIDTH-bit global history register
- use index = idx(pc) XOR zero-extended GHR
- shift GHR left, inserting upd_taken_E, on every valid OP_BRANCH update (non-speculative)
- use the same index function on the update path, from the GHR value before the shift
REQ-021 SHALL, without GSHARE_EN, contain no GHR and index by idx(pc) alone.

Verification
REQ-022 SHALL check reset with CTR_WIDTH=2: pulse rst mid-cycle -> every pc_F reads pred_ctr_F=01, predict_taken_F=0, stats=0.
REQ-023 SHALL check hysteresis with CTR_WIDTH=2: pc 0x40 OP_BRANCH sequence T,T,N,T,N,N -> counter 01,11,11,10,11,10,00.
REQ-024 SHALL check saturating mode with HYSTERESIS=0, CTR_WIDTH=3: 9 taken updates -> counter 011..111, held at 7; then 9 not-taken -> held at 0.
REQ-025 SHALL check jumps and other opcodes: OP_JALR at pc 0x80 -> counter 11; OP_OP at 0x80 -> counter unchanged, stat_branches unchanged.
REQ-026 SHALL check alias and same-cycle behaviour with PHT_ENTRIES=256: pc 0x000 and 0x400 share a counter; same-cycle read/write of 0x000 -> old value, new value next cycle.
REQ-027 SHALL check gshare with GSHARE_EN, GHR_WIDTH=2: branches at 0x10 T then T -> GHR=11, lookup of 0x10 uses index 0x04^0x3=0x07; stat_mispred counts exactly the cycles with mispredict_E=1.

Source files
------------

// File: rtl/pht_predictor.sv
// Pattern history table branch predictor with per-entry counters, hysteresis or saturating update.
// Optional gshare indexing is enabled by defining the GSHARE_EN macro.

package pht_pkg;
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;
endpackage

module pht_predictor
  import pht_pkg::*;
#(
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned HYSTERESIS  = 1,
  parameter int unsigned GHR_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_F,
  output logic                 predict_taken_F,
  output logic [CTR_WIDTH-1:0] pred_ctr_F,
  input  logic                 upd_valid_E,
  input  logic [31:0]          upd_pc_E,
  input  opcode_t              upd_opcode_E,
  input  logic                 upd_taken_E,
  input  logic                 mispredict_E,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispred
);

  localparam int unsigned IDX_W = $clog2(PHT_ENTRIES);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = CTR_WIDTH'((1 << CTR_WIDTH) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

  logic [CTR_WIDTH-1:0] pht_q [PHT_ENTRIES];
  logic [CTR_WIDTH-1:0] pht_d [PHT_ENTRIES];
  logic [31:0]          stat_br_q, stat_br_d;
  logic [31:0]          stat_mp_q, stat_mp_d;
  logic [IDX_W-1:0]     rd_idx_c;
  logic [IDX_W-1:0]     wr_idx_c;
  logic                 is_branch_c;
  logic                 is_jump_c;
  logic                 unused_pc_bits;

`ifdef GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

  // Both paths hash with the committed history; update uses it before the shift.
  assign rd_idx_c = pc_F[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign wr_idx_c = upd_pc_E[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
  assign rd_idx_c = pc_F[IDX_W+1:2];
  assign wr_idx_c = upd_pc_E[IDX_W+1:2];
`endif

  assign unused_pc_bits = ^{pc_F[31:IDX_W+2], pc_F[1:0], upd_pc_E[31:IDX_W+2], upd_pc_E[1:0]};

  assign pred_ctr_F      = pht_q[rd_idx_c];
  assign predict_taken_F = pht_q[rd_idx_c][CTR_WIDTH-1];
  assign stat_branches   = stat_br_q;
  assign stat_mispred    = stat_mp_q;

  assign is_branch_c = (upd_opcode_E == OP_BRANCH);
  assign is_jump_c   = (upd_opcode_E == OP_JAL) || (upd_opcode_E == OP_JALR);

  // Hysteresis jumps to the strong state unless the counter sits at the opposite extreme.
  function automatic logic [CTR_WIDTH-1:0] next_ctr(input logic [CTR_WIDTH-1:0] c,
                                                    input logic taken);
    logic [CTR_WIDTH-1:0] n;
    n = c;
    if (HYSTERESIS != 0) begin
      if (taken) n = (c == '0) ? CTR_WIDTH'(1) : CTR_MAX;
      else       n = (c == CTR_MAX) ? CTR_MAX - CTR_WIDTH'(1) : '0;
    end else begin
      if (taken) n = (c == CTR_MAX) ? c : c + CTR_WIDTH'(1);
      else       n = (c == '0) ? c : c - CTR_WIDTH'(1);
    end
    return n;
  endfunction

  always_comb begin
    pht_d     = pht_q;
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
`ifdef GSHARE_EN
    ghr_d     = ghr_q;
`endif
    if (upd_valid_E) begin
      if (is_branch_c) begin
        pht_d[wr_idx_c] = next_ctr(pht_q[wr_idx_c], upd_taken_E);
        stat_br_d       = stat_br_q + 32'd1;
`ifdef GSHARE_EN
        ghr_d           = GHR_WIDTH'({ghr_q, upd_taken_E});
`endif
      end else if (is_jump_c) begin
        pht_d[wr_idx_c] = CTR_MAX;
      end
      if (mispredict_E) begin
        stat_mp_d = stat_mp_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(PHT_ENTRIES); i++) begin
        pht_q[i] <= CTR_WNT;
      end
      stat_br_q <= '0;
      stat_mp_q <= '0;
`ifdef GSHARE_EN
      ghr_q     <= '0;
`endif
    end else begin
      pht_q     <= pht_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
`ifdef GSHARE_EN
      ghr_q     <= ghr_d;
`endif
    end
  end

endmodule

// File: tb/tb_pht_predictor.sv
// Directed self-checking bench for pht_predictor: default 2-bit hysteresis instance plus a
// 3-bit saturating instance; gshare vectors run when GSHARE_EN is defined.

module tb_pht_predictor;
  import pht_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_F;
  logic        upd_valid_E;
  logic [31:0] upd_pc_E;
  opcode_t     upd_opcode_E;
  logic        upd_taken_E;
  logic        mispredict_E;

  logic        predict_taken_F;
  logic [1:0]  pred_ctr_F;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  logic        sat_taken_F;
  logic [2:0]  sat_ctr_F;
  logic [31:0] sat_branches;
  logic [31:0] sat_mispred;

  int n_checks;
  int n_errors;

  pht_predictor #(
    .PHT_ENTRIES(256), .CTR_WIDTH(2), .HYSTERESIS(1), .GHR_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .pc_F(pc_F),
    .predict_taken_F(predict_taken_F), .pred_ctr_F(pred_ctr_F),
    .upd_valid_E(upd_valid_E), .upd_pc_E(upd_pc_E), .upd_opcode_E(upd_opcode_E),
    .upd_taken_E(upd_taken_E), .mispredict_E(mispredict_E),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  pht_predictor #(
    .PHT_ENTRIES(16), .CTR_WIDTH(3), .HYSTERESIS(0), .GHR_WIDTH(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .pc_F(pc_F),
    .predict_taken_F(sat_taken_F), .pred_ctr_F(sat_ctr_F),
    .upd_valid_E(upd_valid_E), .upd_pc_E(upd_pc_E), .upd_opcode_E(upd_opcode_E),
    .upd_taken_E(upd_taken_E), .mispredict_E(mispredict_E),
    .stat_branches(sat_branches), .stat_mispred(sat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the update lands on the next rising edge.
  task automatic upd(input logic [31:0] pc, input opcode_t op, input logic tk, input logic mp);
    upd_valid_E  = 1'b1;
    upd_pc_E     = pc;
    upd_opcode_E = op;
    upd_taken_E  = tk;
    mispredict_E = mp;
    @(negedge clk);
    upd_valid_E  = 1'b0;
    upd_taken_E  = 1'b0;
    mispredict_E = 1'b0;
  endtask

  task automatic rd(input logic [31:0] pc);
    pc_F = pc;
    #1;
  endtask

  initial begin
    logic tk_seq [6];
    logic mp_seq [6];
    int   ex_seq [6];
    logic all_nt;
    int   ex;

    tk_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    mp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ex_seq = '{3, 3, 2, 3, 2, 0};
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    pc_F = '0;
    upd_valid_E = 1'b0;
    upd_pc_E = '0;
    upd_opcode_E = OP_OP;
    upd_taken_E = 1'b0;
    mispredict_E = 1'b0;

    @(negedge clk);
    rd(32'h40);
    check("rst_ctr", 32'(pred_ctr_F), 32'd1);
    check("rst_taken", 32'(predict_taken_F), 32'd0);
    check("rst_br", stat_branches, 32'd0);
    check("rst_mp", stat_mispred, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef GSHARE_EN
    upd(32'h1C, OP_JAL, 1'b0, 1'b0);
    upd(32'h10, OP_BRANCH, 1'b1, 1'b1);
    upd(32'h10, OP_BRANCH, 1'b1, 1'b0);
    rd(32'h10);
    check("gs_idx7", 32'(pred_ctr_F), 32'd3);
    check("gs_idx7_t", 32'(predict_taken_F), 32'd1);
    rd(32'h1C);
    check("gs_idx4", 32'(pred_ctr_F), 32'd3);
    rd(32'h18);
    check("gs_idx5", 32'(pred_ctr_F), 32'd3);
    rd(32'h14);
    check("gs_idx6", 32'(pred_ctr_F), 32'd1);
    check("gs_br", stat_branches, 32'd2);
    check("gs_mp", stat_mispred, 32'd1);
    upd(32'h10, OP_OP, 1'b1, 1'b1);
    rd(32'h10);
    check("gs_op_keep", 32'(pred_ctr_F), 32'd3);
    check("gs_mp2", stat_mispred, 32'd2);
`else
    rd(32'h40);
    check("hyst_init", 32'(pred_ctr_F), 32'd1);
    for (int k = 0; k < 6; k++) begin
      upd(32'h40, OP_BRANCH, tk_seq[k], mp_seq[k]);
      rd(32'h40);
      check($sformatf("hyst%0d", k), 32'(pred_ctr_F), 32'(ex_seq[k]));
      check($sformatf("hyst_t%0d", k), 32'(predict_taken_F), 32'(ex_seq[k] >= 2));
    end
    check("hyst_br", stat_branches, 32'd6);
    check("hyst_mp", stat_mispred, 32'd2);

    upd(32'h80, OP_JALR, 1'b0, 1'b1);
    rd(32'h80);
    check("jalr", 32'(pred_ctr_F), 32'd3);
    check("jalr_br", stat_branches, 32'd6);
    check("jalr_mp", stat_mispred, 32'd3);
    upd(32'h80, OP_OP, 1'b0, 1'b0);
    rd(32'h80);
    check("op_keep", 32'(pred_ctr_F), 32'd3);
    check("op_br", stat_branches, 32'd6);
    upd(32'h84, OP_JAL, 1'b0, 1'b0);
    rd(32'h84);
    check("jal", 32'(pred_ctr_F), 32'd3);

    upd(32'h400, OP_BRANCH, 1'b1, 1'b0);
    rd(32'h000);
    check("alias", 32'(pred_ctr_F), 32'd3);
    upd_valid_E  = 1'b1;
    upd_pc_E     = 32'h000;
    upd_opcode_E = OP_BRANCH;
    upd_taken_E  = 1'b0;
    rd(32'h000);
    check("same_old", 32'(pred_ctr_F), 32'd3);
    @(negedge clk);
    upd_valid_E = 1'b0;
    #1;
    check("same_new", 32'(pred_ctr_F), 32'd2);
    rd(32'h400);
    check("alias_new", 32'(pred_ctr_F), 32'd2);

    upd_valid_E  = 1'b0;
    upd_pc_E     = 32'h000;
    upd_opcode_E = OP_BRANCH;
    upd_taken_E  = 1'b1;
    mispredict_E = 1'b1;
    @(negedge clk);
    mispredict_E = 1'b0;
    upd_taken_E  = 1'b0;
    rd(32'h000);
    check("inv_ctr", 32'(pred_ctr_F), 32'd2);
    check("inv_br", stat_branches, 32'd8);
    check("inv_mp", stat_mispred, 32'd3);

    // Asynchronous pulse between clock edges clears the whole table.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    all_nt = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rd(32'(i * 4));
      check($sformatf("sweep%0d", i), 32'(pred_ctr_F), 32'd1);
      if (predict_taken_F !== 1'b0) all_nt = 1'b0;
    end
    check("sweep_taken", 32'(all_nt), 32'd1);
    check("pulse_br", stat_branches, 32'd0);
    check("pulse_mp", stat_mispred, 32'd0);

    @(negedge clk);
    upd_valid_E  = 1'b1;
    upd_pc_E     = 32'h200;
    upd_opcode_E = OP_BRANCH;
    upd_taken_E  = 1'b1;
    mispredict_E = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    upd_valid_E  = 1'b0;
    mispredict_E = 1'b0;
    rd(32'h200);
    check("midupd_ctr", 32'(pred_ctr_F), 32'd1);
    check("midupd_br", stat_branches, 32'd0);
    check("midupd_mp", stat_mispred, 32'd0);
    @(negedge clk);

    rd(32'h40);
    check("sat_init", 32'(sat_ctr_F), 32'd3);
    for (int k = 0; k < 9; k++) begin
      upd(32'h40, OP_BRANCH, 1'b1, 1'b0);
      rd(32'h40);
      ex = (k + 4 > 7) ? 7 : k + 4;
      check($sformatf("sat_up%0d", k), 32'(sat_ctr_F), 32'(ex));
    end
    check("sat_up_t", 32'(sat_taken_F), 32'd1);
    for (int k = 0; k < 9; k++) begin
      upd(32'h40, OP_BRANCH, 1'b0, 1'b0);
      rd(32'h40);
      ex = (6 - k < 0) ? 0 : 6 - k;
      check($sformatf("sat_dn%0d", k), 32'(sat_ctr_F), 32'(ex));
    end
    check("sat_dn_t", 32'(sat_taken_F), 32'd0);
    check("sat_br", sat_branches, 32'd18);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
